tile_pixel_index_gen: RTL and testbench

- Producer side of the palette-index interface consumed by the tile pixel decoders.
- Takes the VGA scan coordinate and the 4x4 board state, and emits per pixel a tile value (selects which decoder drives RGB) and a 2-bit palette index (addr_pixel).
- Fetches digit glyph bits from an external synchronous glyph ROM.
- Sits between the VGA timing counter and the decoder/RGB mux.

---
 rtl/tile_pixel_index_gen.sv | 158 +++++++++++++++
 tb/tb_tile_pixel_index_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tile_pixel_index_gen.sv
// Tile pixel index generator: maps the VGA scan position and board state to a
// per-pixel decoder select (tile_val) and 2-bit palette index (pix_idx), with a
// 3-cycle fixed-latency pipeline around an external synchronous glyph ROM.
module tile_pixel_index_gen #(
  parameter int unsigned BOARD_X = 95,
  parameter int unsigned BOARD_Y = 15,
  parameter int unsigned TILE    = 100,
  parameter int unsigned GAP     = 10,
  parameter int unsigned GW      = 64,
  parameter int unsigned GH      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid_in,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [63:0] board,
  output logic [14:0] glyph_addr,
  input  logic        glyph_bit,
  output logic        pix_valid_out,
  output logic [3:0]  tile_val,
  output logic [1:0]  pix_idx,
  output logic        in_board
);

  localparam int unsigned BW    = 4 * TILE + 5 * GAP;
  localparam int unsigned PITCH = TILE + GAP;
  localparam int unsigned GX0   = (TILE - GW) / 2;
  localparam int unsigned GY0   = (TILE - GH) / 2;
  localparam int unsigned VMAX  = 11;

  typedef enum logic [1:0] {
    REG_OUT   = 2'd0,
    REG_FRAME = 2'd1,
    REG_CELL  = 2'd2
  } region_t;

  logic [63:0] board_q;

  // S1 / S2 pipeline registers
  logic        s1_valid, s2_valid;
  region_t     s1_region, s2_region;
  logic [3:0]  s1_val, s2_val;
  logic        s1_glyph, s2_glyph;

  // Classification results for the incoming pixel
  logic [31:0] px, py, lx, ly;
  logic        hit_x, hit_y, in_brd, in_glyph;
  logic [1:0]  col, row;
  logic [3:0]  cell_raw, cell_val;
  region_t     region_c;
  logic [14:0] addr_c;

  // Region, cell and glyph-box decode using range compares only
  always_comb begin
    px       = 32'(h_cnt);
    py       = 32'(v_cnt);
    hit_x    = 1'b0;
    hit_y    = 1'b0;
    col      = 2'd0;
    row      = 2'd0;
    lx       = 32'd0;
    ly       = 32'd0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (px >= BOARD_X + GAP + c * PITCH && px < BOARD_X + GAP + c * PITCH + TILE) begin
        hit_x = 1'b1;
        col   = 2'(c);
        lx    = px - (BOARD_X + GAP + c * PITCH);
      end
      if (py >= BOARD_Y + GAP + c * PITCH && py < BOARD_Y + GAP + c * PITCH + TILE) begin
        hit_y = 1'b1;
        row   = 2'(c);
        ly    = py - (BOARD_Y + GAP + c * PITCH);
      end
    end
    in_brd   = (px >= BOARD_X) && (px < BOARD_X + BW) &&
               (py >= BOARD_Y) && (py < BOARD_Y + BW);
    cell_raw = board_q[{row, col, 2'b00} +: 4];
    cell_val = (cell_raw > 4'(VMAX)) ? 4'(VMAX) : cell_raw;
    in_glyph = hit_x && hit_y &&
               (lx >= GX0) && (lx < GX0 + GW) &&
               (ly >= GY0) && (ly < GY0 + GH);
    if (!in_brd)             region_c = REG_OUT;
    else if (hit_x && hit_y) region_c = REG_CELL;
    else                     region_c = REG_FRAME;
    addr_c   = in_glyph ? {cell_val, 5'(ly - GY0), 6'(lx - GX0)} : 15'd0;
  end

  // S1: register classification, glyph address and frame-start board snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_region  <= REG_OUT;
      s1_val     <= 4'd0;
      s1_glyph   <= 1'b0;
      glyph_addr <= 15'd0;
      board_q    <= 64'd0;
    end else begin
      s1_valid <= pix_valid_in;
      if (pix_valid_in) begin
        s1_region  <= region_c;
        s1_val     <= cell_val;
        s1_glyph   <= in_glyph;
        glyph_addr <= addr_c;
        if (h_cnt == 10'd0 && v_cnt == 10'd0) board_q <= board;
      end
    end
  end

  // S2: delay stage aligned with the glyph ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_region <= REG_OUT;
      s2_val    <= 4'd0;
      s2_glyph  <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      s2_region <= s1_region;
      s2_val    <= s1_val;
      s2_glyph  <= s1_glyph;
    end
  end

  // Output stage: combine S2 decode with the returned glyph bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_out <= 1'b0;
      tile_val      <= 4'd0;
      pix_idx       <= 2'd0;
      in_board      <= 1'b0;
    end else begin
      pix_valid_out <= s2_valid;
      tile_val      <= 4'd0;
      pix_idx       <= 2'd0;
      in_board      <= 1'b0;
      if (s2_valid) begin
        case (s2_region)
          REG_FRAME: begin
            pix_idx  <= 2'd1;
            in_board <= 1'b1;
          end
          REG_CELL: begin
            in_board <= 1'b1;
            if (s2_val == 4'd0) begin
              pix_idx <= 2'd2;
            end else begin
              tile_val <= s2_val;
              pix_idx  <= (s2_glyph && glyph_bit) ? 2'd1 : 2'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tile_pixel_index_gen.sv
// Directed bench for tile_pixel_index_gen with a reference geometry model and
// scoreboard queues for the output bus and the glyph ROM address.
module tb_tile_pixel_index_gen;

  localparam int BX = 95, BY = 15, TL = 100, GP = 10, BWD = 450;
  localparam int GX0 = 18, GY0 = 34, GWD = 64, GHT = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid_in = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic [63:0] board = '0;
  logic [14:0] glyph_addr;
  logic        glyph_bit = 1'b0;
  logic        pix_valid_out;
  logic [3:0]  tile_val;
  logic [1:0]  pix_idx;
  logic        in_board;

  logic        rom_inv = 1'b0;
  logic [63:0] snap = '0;
  logic [14:0] last_addr = '0;
  logic [7:0]  out_q[$];
  logic [14:0] addr_q[$];
  int          checks = 0;
  int          errors = 0;

  tile_pixel_index_gen dut (
    .clk(clk), .rst_n(rst_n), .pix_valid_in(pix_valid_in),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .board(board),
    .glyph_addr(glyph_addr), .glyph_bit(glyph_bit),
    .pix_valid_out(pix_valid_out), .tile_val(tile_val),
    .pix_idx(pix_idx), .in_board(in_board)
  );

  always #5 clk = ~clk;

  // Synchronous glyph ROM: bit pattern is the address LSB, optionally inverted
  always @(posedge clk) glyph_bit <= glyph_addr[0] ^ rom_inv;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: division/modulo geometry, independent of the RTL compares
  task automatic model(input int x, input int y, output logic [7:0] eo, output logic [14:0] ea);
    int rx, ry, kx, ky, ox, oy, lx, ly, v;
    logic glyph;
    logic [3:0] t;
    logic [1:0] idx;
    rx = x - BX;
    ry = y - BY;
    ea = '0;
    if (rx < 0 || rx >= BWD || ry < 0 || ry >= BWD) begin
      eo = {1'b1, 4'd0, 2'd0, 1'b0};
      return;
    end
    kx = rx / (TL + GP); ox = rx % (TL + GP);
    ky = ry / (TL + GP); oy = ry % (TL + GP);
    if (ox < GP || oy < GP) begin
      eo = {1'b1, 4'd0, 2'd1, 1'b1};
      return;
    end
    lx = ox - GP;
    ly = oy - GP;
    v  = int'(snap[4*(4*ky+kx) +: 4]);
    if (v > 11) v = 11;
    glyph = (lx >= GX0) && (lx < GX0 + GWD) && (ly >= GY0) && (ly < GY0 + GHT);
    if (glyph) ea = {4'(v), 5'(ly - GY0), 6'(lx - GX0)};
    if (v == 0) begin
      t = 4'd0; idx = 2'd2;
    end else begin
      t = 4'(v);
      idx = (glyph && (ea[0] ^ rom_inv)) ? 2'd1 : 2'd0;
    end
    eo = {1'b1, t, idx, 1'b1};
  endtask

  // One pixel slot: retire due scoreboard entries, then drive the next input
  task automatic step(input logic v, input int x, input int y);
    logic [7:0]  eo;
    logic [14:0] ea;
    @(negedge clk);
    if (out_q.size() >= 3)
      check("out", {8'd0, pix_valid_out, tile_val, pix_idx, in_board}, {8'd0, out_q.pop_front()});
    if (addr_q.size() >= 1)
      check("glyph_addr", {1'b0, glyph_addr}, {1'b0, addr_q.pop_front()});
    pix_valid_in = v;
    h_cnt = 10'(x);
    v_cnt = 10'(y);
    eo = '0;
    if (v) begin
      model(x, y, eo, ea);
      last_addr = ea;
      if (x == 0 && y == 0) snap = board;
    end
    out_q.push_back(eo);
    addr_q.push_back(last_addr);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0);
  endtask

  initial begin
    // Reset held while valid pixels stream in: every output stays 0
    board = 64'h1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_hold", {8'd0, pix_valid_out, tile_val, pix_idx, in_board}, 16'd0);
      check("rst_addr", {1'b0, glyph_addr}, 16'd0);
      pix_valid_in = 1'b1;
      h_cnt = 10'(150 + i);
      v_cnt = 10'd30;
    end
    @(negedge clk);
    rst_n = 1'b1;
    pix_valid_in = 1'b0;

    // Snapshot load at (0,0), tile body, glyph fetch, regions and cell edges
    board = 64'h1;
    step(1'b1, 0, 0);
    step(1'b1, 150, 30);
    step(1'b1, 130, 60);
    @(posedge clk);
    #1 check("glyph_addr_130_60", {1'b0, glyph_addr}, {1'b0, 4'd1, 5'd1, 6'd7});
    step(1'b1, 50, 50);
    step(1'b1, 100, 100);
    step(1'b1, 250, 50);
    step(1'b1, 204, 30);
    step(1'b1, 205, 30);
    step(1'b1, 544, 464);
    step(1'b1, 545, 100);
    drain();

    // Same glyph pixel with the ROM returning 0
    rom_inv = 1'b1;
    step(1'b1, 130, 60);
    drain();
    rom_inv = 1'b0;

    // Board change mid-frame is invisible until the next (0,0)
    board = 64'h5;
    step(1'b1, 150, 30);
    step(1'b1, 0, 0);
    step(1'b1, 150, 30);
    step(1'b1, 130, 60);
    // Value above 11 clamps to 11; also a populated cell in the last row/column
    board = 64'hE000_0000_0000_000E;
    step(1'b1, 0, 0);
    step(1'b1, 150, 30);
    step(1'b1, 500, 420);
    // Bubble pattern 1,0,1,1
    step(1'b1, 250, 50);
    step(1'b0, 150, 30);
    step(1'b1, 100, 100);
    step(1'b1, 50, 50);
    drain();

    // Reset with pixels in flight: valid output drops without a clock edge
    for (int i = 0; i < 5; i++) step(1'b1, 150 + i, 30);
    @(posedge clk);
    #2 check("pre_rst_valid", {15'd0, pix_valid_out}, 16'd1);
    rst_n = 1'b0;
    #1 check("async_rst", {8'd0, pix_valid_out, tile_val, pix_idx, in_board}, 16'd0);
    out_q.delete();
    addr_q.delete();
    snap = '0;
    last_addr = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_mid", {8'd0, pix_valid_out, tile_val, pix_idx, in_board}, 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pix_valid_in = 1'b0;
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    // Snapshot was cleared, so cell (0,0) is empty until the next (0,0)
    step(1'b1, 150, 30);
    step(1'b1, 0, 0);
    step(1'b1, 150, 30);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
